// File: rtl/snoop_bus_ctrl.sv
// Shared snoop-bus controller for a two-cache MSI system: per-cache request FIFOs,
// round-robin arbitration, one broadcast at a time, with an optional remote write-back phase.
module snoop_bus_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned BUS_CYCLES = 2,
    parameter int unsigned WB_CYCLES  = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    input  logic [3:0]            req_op,
    input  logic [2*ADDR_W-1:0]   req_addr,
    output logic [1:0]            req_ready,
    input  logic                  snoop_excl,
    output logic                  bus_valid,
    output logic [1:0]            bus_op,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic                  bus_src,
    output logic                  bus_wb,
    output logic [1:0]            done
);

    localparam int unsigned MAX_CYC = (BUS_CYCLES > WB_CYCLES) ? BUS_CYCLES : WB_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned ENT_W   = 2 + ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_WB, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       excl_q, excl_d;
    logic                       last_q, last_d;
    logic [1:0]                 op_q, op_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic                       src_q, src_d;
    logic                       bus_valid_d, bus_wb_d;
    logic [1:0]                 done_d;
    logic [1:0]                 pop;
    logic [1:0]                 nonempty;
    logic [1:0][ENT_W-1:0]      head;
    logic                       grant;

    // Per-cache 2-entry shift FIFO; read_hit is accepted but never stored
    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [1:0]        cnt;
        logic [1:0]        cnt_nx;
        logic [1:0]        wr_pos;
        logic [ENT_W-1:0]  ent0, ent1;
        logic [1:0]        in_op;
        logic [ADDR_W-1:0] in_addr;
        logic              push;
        logic              rdy;

        assign in_op   = req_op[2*g +: 2];
        assign in_addr = req_addr[g*ADDR_W +: ADDR_W];
        assign push    = req_valid[g] && (cnt < 2'd2) && (in_op != 2'b10);
        assign wr_pos  = cnt - 2'(pop[g]);
        assign cnt_nx  = cnt + 2'(push) - 2'(pop[g]);

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt  <= 2'd0;
                ent0 <= '0;
                ent1 <= '0;
                rdy  <= 1'b1;
            end else begin
                if (pop[g]) ent0 <= ent1;
                if (push) begin
                    if (wr_pos[0]) ent1 <= {in_op, in_addr};
                    else           ent0 <= {in_op, in_addr};
                end
                cnt <= cnt_nx;
                rdy <= (cnt_nx < 2'd2);
            end
        end

        assign req_ready[g] = rdy;
        assign nonempty[g]  = (cnt != 2'd0);
        assign head[g]      = ent0;
    end

    assign grant = nonempty[~last_q] ? ~last_q : last_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            excl_q    <= 1'b0;
            last_q    <= 1'b1;
            op_q      <= '0;
            addr_q    <= '0;
            src_q     <= 1'b0;
            bus_valid <= 1'b0;
            bus_op    <= '0;
            bus_addr  <= '0;
            bus_src   <= 1'b0;
            bus_wb    <= 1'b0;
            done      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            excl_q    <= excl_d;
            last_q    <= last_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            src_q     <= src_d;
            bus_valid <= bus_valid_d;
            bus_op    <= bus_valid_d ? op_d   : '0;
            bus_addr  <= bus_valid_d ? addr_d : '0;
            bus_src   <= bus_valid_d ? src_d  : 1'b0;
            bus_wb    <= bus_wb_d;
            done      <= done_d;
        end
    end

    // Next state plus next values of the registered bus outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        excl_d      = excl_q;
        last_d      = last_q;
        op_d        = op_q;
        addr_d      = addr_q;
        src_d       = src_q;
        pop         = 2'b00;
        bus_valid_d = 1'b0;
        bus_wb_d    = 1'b0;
        done_d      = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (|nonempty) begin
                    pop[grant]  = 1'b1;
                    op_d        = head[grant][ENT_W-1 -: 2];
                    addr_d      = head[grant][ADDR_W-1:0];
                    src_d       = grant;
                    last_d      = grant;
                    cnt_d       = CNT_W'(BUS_CYCLES - 1);
                    state_d     = S_BUS;
                    bus_valid_d = 1'b1;
                end
            end
            S_BUS: begin
                excl_d      = excl_q | snoop_excl;
                bus_valid_d = 1'b1;
                if (cnt_q == '0) begin
                    // Invalidates never need the owner's data, so exclusivity is ignored
                    if (excl_d && (op_q != 2'b11)) begin
                        state_d  = S_WB;
                        cnt_d    = CNT_W'(WB_CYCLES - 1);
                        bus_wb_d = 1'b1;
                    end else begin
                        state_d        = S_DONE;
                        bus_valid_d    = 1'b0;
                        done_d[src_q]  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WB: begin
                bus_valid_d = 1'b1;
                bus_wb_d    = 1'b1;
                if (cnt_q == '0) begin
                    state_d       = S_DONE;
                    bus_valid_d   = 1'b0;
                    bus_wb_d      = 1'b0;
                    done_d[src_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                excl_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed self-checking bench for snoop_bus_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_snoop_bus_ctrl;

    logic        clock;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [3:0]  req_op;
    logic [15:0] req_addr;
    logic [1:0]  req_ready;
    logic        snoop_excl;
    logic        bus_valid;
    logic [1:0]  bus_op;
    logic [7:0]  bus_addr;
    logic        bus_src;
    logic        bus_wb;
    logic [1:0]  done;
    logic [14:0] obs;

    int errors = 0;
    int checks = 0;

    snoop_bus_ctrl #(.ADDR_W(8), .BUS_CYCLES(2), .WB_CYCLES(3)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_ready(req_ready), .snoop_excl(snoop_excl),
        .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_src(bus_src),
        .bus_wb(bus_wb), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign obs = {bus_valid, bus_op, bus_addr, bus_src, bus_wb, done};

    function automatic logic [14:0] mk(input logic v, input logic [1:0] op, input logic [7:0] a,
                                       input logic s, input logic wb, input logic [1:0] d);
        return {v, op, a, s, wb, d};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 2'b00; req_op = 4'b0; req_addr = 16'h0; snoop_excl = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (obs !== 15'h0) begin errors++; $display("FAIL reset_outputs: obs=%h exp=%h", obs, 15'h0); end
        checks++;
        if (req_ready !== 2'b11) begin errors++; $display("FAIL reset_ready: got=%b exp=11", req_ready); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_read_miss();
        logic [14:0] exp_v [5];
        exp_v[0] = '0;
        exp_v[1] = mk(1'b1, 2'b00, 8'h3C, 1'b0, 1'b0, 2'b00);
        exp_v[2] = exp_v[1];
        exp_v[3] = mk(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b01);
        exp_v[4] = '0;
        req_valid = 2'b01; req_op = 4'b0000; req_addr = 16'h003C;
        for (int e = 0; e < 5; e++) begin
            @(negedge clock);
            if (e == 0) req_valid = 2'b00;
            checks++;
            if (obs !== exp_v[e]) begin
                errors++; $display("FAIL read_miss e%0d: obs=%h exp=%h", e, obs, exp_v[e]);
            end
        end
        checks++;
        if (req_ready !== 2'b11) begin errors++; $display("FAIL read_miss_ready: got=%b exp=11", req_ready); end
    endtask

    task automatic test_excl_writeback();
        logic [14:0] exp_v [8];
        exp_v[0] = '0;
        for (int e = 1; e <= 2; e++) exp_v[e] = mk(1'b1, 2'b01, 8'h11, 1'b1, 1'b0, 2'b00);
        for (int e = 3; e <= 5; e++) exp_v[e] = mk(1'b1, 2'b01, 8'h11, 1'b1, 1'b1, 2'b00);
        exp_v[6] = mk(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b10);
        exp_v[7] = '0;
        req_valid = 2'b10; req_op = 4'b0100; req_addr = 16'h1100;
        for (int e = 0; e < 8; e++) begin
            @(negedge clock);
            checks++;
            if (obs !== exp_v[e]) begin
                errors++; $display("FAIL excl_wb e%0d: obs=%h exp=%h", e, obs, exp_v[e]);
            end
            if (e == 0) req_valid = 2'b00;
            if (e == 1) snoop_excl = 1'b1;
            if (e == 2) snoop_excl = 1'b0;
        end
    endtask

    task automatic test_contention();
        logic [1:0]  op_t   [4];
        logic [7:0]  addr_t [4];
        logic [14:0] exp_v;
        logic [1:0]  exp_r;
        int k, ph;
        op_t[0] = 2'b00; addr_t[0] = 8'hA0;
        op_t[1] = 2'b01; addr_t[1] = 8'hB0;
        op_t[2] = 2'b01; addr_t[2] = 8'hA1;
        op_t[3] = 2'b00; addr_t[3] = 8'hB1;
        req_valid = 2'b11; req_op = 4'b0100; req_addr = 16'hB0A0;
        for (int e = 0; e < 17; e++) begin
            @(negedge clock);
            if (e == 0) begin
                exp_v = '0;
            end else begin
                k  = (e - 1) / 4;
                ph = (e - 1) % 4;
                if (ph < 2)       exp_v = mk(1'b1, op_t[k], addr_t[k], k[0], 1'b0, 2'b00);
                else if (ph == 2) exp_v = mk(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, k[0] ? 2'b10 : 2'b01);
                else              exp_v = '0;
            end
            exp_r = (e >= 1 && e <= 4) ? 2'b01 : 2'b11;
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL contention e%0d: obs=%h exp=%h", e, obs, exp_v);
            end
            checks++;
            if (req_ready !== exp_r) begin
                errors++; $display("FAIL contention_ready e%0d: got=%b exp=%b", e, req_ready, exp_r);
            end
            if (e == 0) begin req_op = 4'b0001; req_addr = 16'hB1A1; end
            if (e == 1) req_valid = 2'b00;
        end
    endtask

    task automatic test_hits();
        logic [14:0] exp_v [7];
        exp_v[0] = '0;
        exp_v[1] = mk(1'b1, 2'b11, 8'h20, 1'b0, 1'b0, 2'b00);
        exp_v[2] = exp_v[1];
        exp_v[3] = mk(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b01);
        for (int e = 4; e < 7; e++) exp_v[e] = '0;
        req_valid = 2'b01; req_op = 4'b0011; req_addr = 16'h0020; snoop_excl = 1'b1;
        for (int e = 0; e < 7; e++) begin
            @(negedge clock);
            checks++;
            if (obs !== exp_v[e]) begin
                errors++; $display("FAIL hits e%0d: obs=%h exp=%h", e, obs, exp_v[e]);
            end
            checks++;
            if (req_ready !== 2'b11) begin
                errors++; $display("FAIL hits_ready e%0d: got=%b exp=11", e, req_ready);
            end
            if (e == 0) begin req_op = 4'b0010; req_addr = 16'h0021; end
            if (e == 1) req_valid = 2'b00;
            if (e == 3) snoop_excl = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] exp_v [5];
        exp_v[0] = '0;
        exp_v[1] = mk(1'b1, 2'b01, 8'h55, 1'b0, 1'b0, 2'b00);
        exp_v[2] = exp_v[1];
        exp_v[3] = mk(1'b1, 2'b01, 8'h55, 1'b0, 1'b1, 2'b00);
        exp_v[4] = exp_v[3];
        req_valid = 2'b01; req_op = 4'b0001; req_addr = 16'h0055;
        for (int e = 0; e < 5; e++) begin
            @(negedge clock);
            checks++;
            if (obs !== exp_v[e]) begin
                errors++; $display("FAIL reset_mid e%0d: obs=%h exp=%h", e, obs, exp_v[e]);
            end
            if (e == 0) begin req_valid = 2'b10; req_op = 4'b0000; req_addr = 16'h6600; end
            if (e == 1) begin req_valid = 2'b00; snoop_excl = 1'b1; end
            if (e == 2) snoop_excl = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 15'h0) begin errors++; $display("FAIL reset_mid_async: obs=%h exp=%h", obs, 15'h0); end
        checks++;
        if (req_ready !== 2'b11) begin errors++; $display("FAIL reset_mid_ready: got=%b exp=11", req_ready); end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(negedge clock);
            checks++;
            if (obs !== 15'h0) begin
                errors++; $display("FAIL reset_mid_quiet c%0d: obs=%h exp=%h", e, obs, 15'h0);
            end
        end
        req_valid = 2'b01; req_op = 4'b0000; req_addr = 16'h0077;
        for (int e = 0; e < 5; e++) begin
            @(negedge clock);
            if (e == 0) req_valid = 2'b00;
            if (e == 1 || e == 2) begin
                checks++;
                if (obs !== mk(1'b1, 2'b00, 8'h77, 1'b0, 1'b0, 2'b00)) begin
                    errors++; $display("FAIL after_reset_grant e%0d: obs=%h", e, obs);
                end
            end
            if (e == 3) begin
                checks++;
                if (obs !== mk(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b01)) begin
                    errors++; $display("FAIL after_reset_done: obs=%h exp done=01", obs);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_excl_writeback();
        test_contention();
        test_hits();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
